// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers host writes and issues one
// start strobe per byte, paced by the transmitter's active/done feedback.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_byte,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic              o_tx_dv,
  output logic [7:0]        o_tx_byte
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACTIVE = 2'd1,
    WAIT_DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r;
  logic              tx_dv_r;
  logic [7:0]        tx_byte_r;
  logic              full_s;
  logic              empty_s;
  logic              wr_accept_s;
  logic              pop_s;

  // Flags come from the registered count, so a write is never popped in its own cycle.
  assign full_s      = (count_r == FULL_COUNT);
  assign empty_s     = (count_r == {(ADDR_W+1){1'b0}});
  assign wr_accept_s = i_wr_en & ~full_s;

  // Next-state and pop decision for the transmit sequencer.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && !i_tx_active) begin
          pop_s   = 1'b1;
          state_s = WAIT_ACTIVE;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_ACTIVE: begin
        if (i_tx_active) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_ACTIVE;
        end
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= i_wr_byte;
    end
  end

  // Pointers, occupancy count and the overflow pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= i_wr_en & full_s;
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_accept_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Transmitter interface: one-cycle strobe, byte held until the next pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_dv_r   <= 1'b0;
      tx_byte_r <= 8'h00;
    end else begin
      tx_dv_r <= pop_s;
      if (pop_s) begin
        tx_byte_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign o_full     = full_s;
  assign o_empty    = empty_s;
  assign o_count    = count_r;
  assign o_overflow = overflow_r;
  assign o_tx_dv    = tx_dv_r;
  assign o_tx_byte  = tx_byte_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic
// against a queue-based reference model and a simple transmitter model.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_wr_en = 1'b0;
  logic [7:0]        i_wr_byte = 8'h00;
  logic              o_full;
  logic              o_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic              i_tx_active = 1'b0;
  logic              i_tx_done = 1'b0;
  logic              o_tx_dv;
  logic [7:0]        o_tx_byte;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_byte(i_wr_byte),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_overflow(o_overflow),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done),
    .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queued bytes, sequencer phase (0 idle, 1 issued, 2 transmitting).
  logic [7:0] byte_q[$];
  int         phase = 0;
  logic [7:0] last_byte = 8'h00;
  int         ovf_seen = 0;

  // Transmitter model state.
  int tx_rem = 0;
  bit tx_finish = 1'b0;
  bit hold_busy = 1'b0;
  bit spurious_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply current inputs, predict the edge outcome, compare, step the transmitter.
  task automatic cycle();
    logic       a_wr;
    logic [7:0] a_b;
    logic       a_act;
    logic       a_done;
    logic       a_rst;
    bit         pop;
    bit         acc;
    bit         ovf;
    a_wr = i_wr_en; a_b = i_wr_byte; a_act = i_tx_active; a_done = i_tx_done; a_rst = i_rst;
    pop = 1'b0; acc = 1'b0; ovf = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    if (a_rst) begin
      byte_q.delete();
      phase = 0;
      last_byte = 8'h00;
    end else begin
      pop = (phase == 0) && (byte_q.size() > 0) && !a_act;
      acc = a_wr && (byte_q.size() < DEPTH);
      ovf = a_wr && !acc;
      if (pop) begin
        last_byte = byte_q.pop_front();
        phase = 1;
      end else if (phase == 1 && a_act) begin
        phase = 2;
      end else if (phase == 2 && a_done) begin
        phase = 0;
      end
      if (acc) byte_q.push_back(a_b);
    end
    check_eq("tx_dv", {31'd0, o_tx_dv}, {31'd0, pop});
    check_eq("tx_byte", {24'd0, o_tx_byte}, {24'd0, last_byte});
    check_eq("count", {27'd0, o_count}, byte_q.size());
    check_eq("empty", {31'd0, o_empty}, {31'd0, (byte_q.size() == 0)});
    check_eq("full", {31'd0, o_full}, {31'd0, (byte_q.size() == DEPTH)});
    check_eq("overflow", {31'd0, o_overflow}, {31'd0, ovf});
    if (o_overflow) ovf_seen++;
    i_tx_done = 1'b0;
    if (o_tx_dv) begin
      tx_rem = int'($urandom_range(8, 3));
      tx_finish = 1'b0;
    end
    if (tx_rem > 0) begin
      i_tx_active = 1'b1;
      tx_rem--;
      if (tx_rem == 0) tx_finish = 1'b1;
    end else if (tx_finish) begin
      i_tx_active = 1'b0;
      i_tx_done = 1'b1;
      tx_finish = 1'b0;
    end else begin
      i_tx_active = 1'b0;
      if (spurious_en && $urandom_range(7, 0) == 0) i_tx_done = 1'b1;
    end
    if (hold_busy) i_tx_active = 1'b1;
  endtask

  task automatic wr(input logic [7:0] b);
    i_wr_en = 1'b1;
    i_wr_byte = b;
    cycle();
    i_wr_en = 1'b0;
  endtask

  // Run until the model and transmitter are both quiet, within a cycle budget.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(byte_q.size() == 0 && phase == 0 && tx_rem == 0 && !tx_finish &&
             !i_tx_active && !i_tx_done) && n < 3000) begin
      cycle();
      n++;
    end
    check_eq({tag, "_drain_in_budget"}, {31'd0, (n < 3000)}, 32'd1);
    check_eq({tag, "_empty_at_end"}, {31'd0, o_empty}, 32'd1);
  endtask

  initial begin
    int ovf_before;
    int n;
    @(negedge i_clk);
    cycle();
    cycle();
    i_rst = 1'b0;

    // 1: single byte
    wr(8'hA5);
    check_eq("t1_count_one", {27'd0, o_count}, 32'd1);
    cycle();
    check_eq("t1_dv", {31'd0, o_tx_dv}, 32'd1);
    check_eq("t1_byte", {24'd0, o_tx_byte}, 32'hA5);
    drain("t1");

    // 2: burst 01..05
    for (int i = 1; i <= 5; i++) wr(8'(i));
    drain("t2");

    // 3: fill and overflow with transmitter held busy
    hold_busy = 1'b1;
    i_tx_active = 1'b1;
    ovf_before = ovf_seen;
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
    check_eq("t3_full", {31'd0, o_full}, 32'd1);
    check_eq("t3_count16", {27'd0, o_count}, 32'd16);
    wr(8'hEE);
    check_eq("t3_ovf_pulse", {31'd0, o_overflow}, 32'd1);
    cycle();
    check_eq("t3_ovf_once", ovf_seen - ovf_before, 32'd1);
    hold_busy = 1'b0;
    i_tx_active = 1'b0;
    drain("t3");

    // 4: wrap-around
    hold_busy = 1'b1;
    i_tx_active = 1'b1;
    for (int i = 0; i < 12; i++) wr(8'(8'h80 + i));
    hold_busy = 1'b0;
    i_tx_active = 1'b0;
    drain("t4a");
    for (int i = 0; i < 10; i++) wr(8'(8'hC0 + i));
    drain("t4b");

    // 5: write coincident with a pop at count 3
    hold_busy = 1'b1;
    i_tx_active = 1'b1;
    for (int i = 0; i < 3; i++) wr(8'(8'h10 + i));
    hold_busy = 1'b0;
    i_tx_active = 1'b0;
    wr(8'h99);
    check_eq("t5_count_stays3", {27'd0, o_count}, 32'd3);
    check_eq("t5_dv", {31'd0, o_tx_dv}, 32'd1);
    drain("t5");

    // 6: asynchronous reset while transmitting with 4 queued
    for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
    n = 0;
    while (phase != 2 && n < 50) begin
      cycle();
      n++;
    end
    check_eq("t6_reach_wait_done", {31'd0, (phase == 2)}, 32'd1);
    check_eq("t6_queued4", {27'd0, o_count}, 32'd4);
    #2 i_rst = 1'b1;
    #1;
    check_eq("t6_rst_count", {27'd0, o_count}, 32'd0);
    check_eq("t6_rst_empty", {31'd0, o_empty}, 32'd1);
    check_eq("t6_rst_dv", {31'd0, o_tx_dv}, 32'd0);
    check_eq("t6_rst_byte", {24'd0, o_tx_byte}, 32'd0);
    cycle();
    i_rst = 1'b0;
    for (int i = 0; i < 30; i++) cycle();
    drain("t6");

    // Random traffic with occasional stray done pulses
    spurious_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      i_wr_en = ($urandom_range(3, 0) == 0);
      i_wr_byte = 8'($urandom);
      cycle();
    end
    i_wr_en = 1'b0;
    spurious_en = 1'b0;
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO and transmit sequencer placed directly upstream of the UART transmitter. Host logic writes bytes at any rate up to one per clock. The block drains them one at a time into the transmitter's data-valid/byte inputs and paces each byte on the transmitter's active/done feedback. Its outputs connect to the top level's i_tx_dv and i_tx_byte. Its feedback inputs connect to the transmitter's o_Tx_Active and o_Tx_Done.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2 and at least 2
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
i_clk  input  1  system clock; all logic is on the rising edge
i_rst  input  1  asynchronous, active-high reset
i_wr_en  input  1  write strobe; one byte per cycle while high
i_wr_byte  input  8  byte to enqueue
o_full  output  1  FIFO holds DEPTH entries
o_empty  output  1  FIFO holds 0 entries
o_count  output  ADDR_W+1  current occupancy, 0..DEPTH
o_overflow  output  1  one-cycle pulse when a write is dropped
i_tx_active  input  1  transmitter busy (from uart_tx o_Tx_Active)
i_tx_done  input  1  transmitter finished a byte, one-cycle pulse (from uart_tx o_Tx_Done)
o_tx_dv  output  1  one-cycle start strobe to the transmitter
o_tx_byte  output  8  byte presented to the transmitter

Behaviour:
- Reset (async assert, sync release) clears:
  - wr_ptr, rd_ptr and o_count to 0
  - o_empty=1, o_full=0, o_overflow=0
  - o_tx_dv=0, o_tx_byte=8'h00
  - FSM to IDLE
- Storage: DEPTH x 8 register array. Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- o_count is a registered counter:
  - +1 on an accepted write only
  - -1 on a pop only
  - unchanged when a write and a pop happen in the same cycle
- o_empty = (o_count==0) and o_full = (o_count==DEPTH), both derived from the registered count.
- Write acceptance: a write is accepted when i_wr_en=1 and o_full=0.
  - i_wr_en=1 with o_full=1 drops the byte and pulses o_overflow high for exactly 1 cycle.
  - This holds even if a pop occurs in the same cycle; full always blocks writes.
  - Pointers and count are unchanged by a dropped write.
- FSM states: IDLE, WAIT_ACTIVE, WAIT_DONE.
  - IDLE: if o_empty=0 and i_tx_active=0, pop in this cycle:
    - o_tx_byte <= mem[rd_ptr], o_tx_dv <= 1, rd_ptr++, count--
    - go to WAIT_ACTIVE
    - otherwise stay in IDLE.
  - WAIT_ACTIVE: o_tx_dv returns to 0, so it is exactly 1 cycle wide. Stay until i_tx_active=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until i_tx_done=1, then go to IDLE. The next pop occurs no earlier than the cycle after done, and only once i_tx_active=0.
- o_tx_byte holds its value from a pop until the next pop.
- Latency: with the FIFO empty in IDLE and i_tx_active=0, a byte written at edge k raises o_tx_dv after edge k+1.
- Back-to-back: successive o_tx_dv pulses are separated by at least one full transmitter frame. No byte is ever issued while i_tx_active=1.
- Ordering: bytes leave strictly in write order; no duplication or loss except overflow drops.
- Write to an empty FIFO in the same cycle the FSM samples o_empty: no pop that cycle, because empty is registered. The pop occurs on the next cycle.
- i_tx_done arriving while in IDLE or WAIT_ACTIVE is ignored.
- Reset mid-transfer: the FIFO contents are discarded and o_tx_dv drops immediately. The transmitter completes its current frame independently; the FSM waits for i_tx_active=0 before the next pop.

Test Plan:
1. Reset, single byte: write 8'hA5 with the transmitter model idle → o_tx_dv one-cycle pulse with o_tx_byte=8'hA5 two edges after the write; o_count goes 0→1→0.
2. Burst and ordering: write 8'h01..8'h05 on consecutive cycles → exactly 5 o_tx_dv pulses carrying 01,02,03,04,05 in order. Each pulse comes only after the previous i_tx_done, with no pulse while i_tx_active=1. o_empty=1 at the end.
3. Fill and overflow: hold the transmitter busy (i_tx_active=1), write 17 bytes with DEPTH=16 → o_full=1 after 16 writes, o_count=16, and the 17th write gives one o_overflow pulse. Release the transmitter → 16 bytes drain with the 17th absent.
4. Wrap-around: push 12, drain 12, then push 10 → all 10 issue in order with correct data, exercising rd/wr pointer wrap past index 15.
5. Simultaneous events: with o_count=3, perform a write in the same cycle as a pop → o_count stays 3, and the new byte is transmitted fourth.
6. Async reset mid-operation: assert i_rst while in WAIT_DONE with 4 bytes queued → outputs immediately reach their reset values (o_empty=1, o_count=0, o_tx_dv=0). After release, no o_tx_dv occurs until a new write.
